// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display scheduler: state encoding,
// message kinds and default timing parameters.
`timescale 1ns/1ps
package display_pkg;

  typedef enum logic {
    SHOW_NUM = 1'b0,
    SHOW_MSG = 1'b1
  } state_e;

  localparam logic MSG_PASS = 1'b1;
  localparam logic MSG_FAIL = 1'b0;

  // 100 MHz system clock -> 1 kHz digit scan, message held for 2 s.
  localparam int DEFAULT_REFRESH_DIV = 100000;
  localparam int DEFAULT_HOLD_TICKS  = 2000;

endpackage

// File: rtl/refresh_prescaler.sv
// Free-running divider producing a one-cycle refresh tick every REFRESH_DIV
// clocks; the first tick appears REFRESH_DIV cycles after reset release.
`timescale 1ns/1ps
module refresh_prescaler
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV,
  parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
  input  logic clk_pi,
  input  logic rst_pi,
  output logic tick_po
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk_pi) begin
    if (rst_pi) begin
      cnt     <= '0;
      tick_po <= 1'b0;
    end else begin
      tick_po <= (cnt == LAST);
      cnt     <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// Arbitrates the four-digit display between a live number source and a timed
// pass/fail message that pre-empts it for HOLD_TICKS refresh ticks.
`timescale 1ns/1ps
module display_scheduler
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV,
  parameter int HOLD_TICKS  = DEFAULT_HOLD_TICKS,
  parameter int CNT_W       = 17,
  parameter int HOLD_W      = 11
) (
  input  logic        clk_pi,
  input  logic        rst_pi,
  input  logic [15:0] num_pi,
  input  logic        num_valid_pi,
  input  logic        msg_req_pi,
  input  logic        msg_value_pi,
  input  logic        clear_pi,
  output logic        clk_en_po,
  output logic [15:0] num_po,
  output logic        p_en_po,
  output logic        p_value_po,
  output logic        busy_po
);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);

  state_e            state, next_state;
  logic [HOLD_W-1:0] hold, hold_nxt;
  logic              p_value_nxt;
  logic [15:0]       shadow;

  refresh_prescaler #(
    .REFRESH_DIV (REFRESH_DIV),
    .CNT_W       (CNT_W)
  ) u_prescaler (
    .clk_pi  (clk_pi),
    .rst_pi  (rst_pi),
    .tick_po (clk_en_po)
  );

  // NOTE: every always_comb output gets a default first, so no path through
  // the case/if tree can leave a value unassigned and infer a latch.
  always_comb begin
    next_state  = state;
    hold_nxt    = hold;
    p_value_nxt = p_value_po;
    unique case (state)
      SHOW_NUM: begin
        if (msg_req_pi && !clear_pi) begin
          next_state  = SHOW_MSG;
          hold_nxt    = HOLD_LOAD;
          p_value_nxt = msg_value_pi;
        end
      end
      SHOW_MSG: begin
        if (clear_pi) begin
          next_state = SHOW_NUM;
          hold_nxt   = '0;
        end else if (msg_req_pi) begin
          // A fresh request restarts the full hold, even on the expiring tick.
          hold_nxt    = HOLD_LOAD;
          p_value_nxt = msg_value_pi;
        end else if (clk_en_po && hold != '0) begin
          hold_nxt = hold - HOLD_W'(1);
          if (hold == HOLD_W'(1)) next_state = SHOW_NUM;
        end
      end
      default: next_state = SHOW_NUM;
    endcase
  end

  always_ff @(posedge clk_pi) begin
    if (rst_pi) begin
      state      <= SHOW_NUM;
      hold       <= '0;
      p_value_po <= MSG_FAIL;
      shadow     <= '0;
      num_po     <= '0;
    end else begin
      state      <= next_state;
      hold       <= hold_nxt;
      p_value_po <= p_value_nxt;
      if (num_valid_pi) shadow <= num_pi;
      // The displayed number is frozen while a message owns the display.
      if (state == SHOW_NUM) num_po <= shadow;
    end
  end

  assign p_en_po = (state == SHOW_MSG);
  assign busy_po = (state == SHOW_MSG);

endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a tick/event-count model.
`timescale 1ns/1ps
module tb_display_scheduler;
  import display_pkg::*;

  localparam int DIV  = 4;
  localparam int HOLD = 3;

  logic        clk_pi = 1'b0;
  logic        rst_pi = 1'b1;
  logic [15:0] num_pi = '0;
  logic        num_valid_pi = 1'b0;
  logic        msg_req_pi = 1'b0;
  logic        msg_value_pi = 1'b0;
  logic        clear_pi = 1'b0;
  logic        clk_en_po;
  logic [15:0] num_po;
  logic        p_en_po;
  logic        p_value_po;
  logic        busy_po;

  always #5 clk_pi = ~clk_pi;

  display_scheduler #(
    .REFRESH_DIV (DIV),
    .HOLD_TICKS  (HOLD),
    .CNT_W       (2),
    .HOLD_W      (2)
  ) dut (
    .clk_pi       (clk_pi),
    .rst_pi       (rst_pi),
    .num_pi       (num_pi),
    .num_valid_pi (num_valid_pi),
    .msg_req_pi   (msg_req_pi),
    .msg_value_pi (msg_value_pi),
    .clear_pi     (clear_pi),
    .clk_en_po    (clk_en_po),
    .num_po       (num_po),
    .p_en_po      (p_en_po),
    .p_value_po   (p_value_po),
    .busy_po      (busy_po)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: edges since reset, whether a message is showing and how many ticks
  // it has seen since its last (re)start, the latched kind, and the numbers.
  int          m_n;
  bit          m_tick;
  bit          m_active;
  int          m_seen;
  bit          m_value;
  logic [15:0] m_shadow;
  logic [15:0] m_num;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_edge();
    bit consumed;
    if (rst_pi) begin
      m_n = 0; m_tick = 0; m_active = 0; m_seen = 0; m_value = 0;
      m_shadow = '0; m_num = '0;
    end else begin
      consumed = m_tick;
      m_n++;
      m_tick = (m_n % DIV == 0);
      if (!m_active) m_num = m_shadow;
      if (num_valid_pi) m_shadow = num_pi;
      if (clear_pi) m_active = 0;
      else if (msg_req_pi) begin
        m_active = 1; m_seen = 0; m_value = msg_value_pi;
      end else if (m_active && consumed) begin
        m_seen++;
        if (m_seen == HOLD) m_active = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("clk_en", 32'(clk_en_po), 32'(m_tick));
    check("num",    32'(num_po),    32'(m_num));
    check("p_en",   32'(p_en_po),   32'(m_active));
    check("busy",   32'(busy_po),   32'(m_active));
    check("p_value",32'(p_value_po),32'(m_value));
  endtask

  task automatic step(input bit rst, input bit v, input logic [15:0] n,
                      input bit req, input bit val, input bit clr);
    rst_pi = rst; num_valid_pi = v; num_pi = n;
    msg_req_pi = req; msg_value_pi = val; clear_pi = clr;
    @(posedge clk_pi);
    model_edge();
    @(negedge clk_pi);
    compare_all();
  endtask

  task automatic idle();
    step(0, 0, 16'h0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 16'h0, 0, 0, 0);
    step(1, 0, 16'h0, 0, 0, 0);
  endtask

  initial begin
    // Idle after reset: ticks on cycles 4, 8, 12, 16, 20.
    do_reset();
    check("rst_num", 32'(num_po), 32'h0);
    check("rst_p_en", 32'(p_en_po), 32'h0);
    for (int i = 1; i <= 20; i++) begin
      idle();
      check($sformatf("tick_c%0d", i), 32'(clk_en_po), (i % 4 == 0) ? 32'h1 : 32'h0);
    end
    check("idle_num", 32'(num_po), 32'h0);
    check("idle_p_en", 32'(p_en_po), 32'h0);

    // Number capture latency.
    do_reset();
    step(0, 1, 16'hBEEF, 0, 0, 0);
    check("num_c1", 32'(num_po), 32'h0);
    idle();
    check("num_c2", 32'(num_po), 32'hBEEF);
    check("num_c2_p_en", 32'(p_en_po), 32'h0);

    // Pass message from cycle 6 to 16, numbers frozen, last update shown after.
    do_reset();
    idle();
    step(0, 1, 16'hBEEF, 0, 0, 0);
    for (int i = 3; i <= 5; i++) idle();
    step(0, 0, 16'h0, 1, MSG_PASS, 0);
    check("msg_c6_p_en", 32'(p_en_po), 32'h1);
    check("msg_c6_val", 32'(p_value_po), 32'h1);
    check("msg_c6_busy", 32'(busy_po), 32'h1);
    step(0, 1, 16'h1234, 0, 0, 0);
    step(0, 1, 16'h5678, 0, 0, 0);
    for (int i = 9; i <= 16; i++) idle();
    check("msg_c16_p_en", 32'(p_en_po), 32'h1);
    check("msg_c16_num", 32'(num_po), 32'hBEEF);
    idle();
    check("msg_c17_p_en", 32'(p_en_po), 32'h0);
    check("msg_c17_busy", 32'(busy_po), 32'h0);
    check("msg_c17_num", 32'(num_po), 32'hBEEF);
    idle();
    check("msg_c18_num", 32'(num_po), 32'h5678);

    // Re-request one cycle before the expiring tick reloads the hold.
    do_reset();
    for (int i = 1; i <= 5; i++) idle();
    step(0, 0, 16'h0, 1, MSG_PASS, 0);
    for (int i = 7; i <= 15; i++) idle();
    step(0, 0, 16'h0, 1, MSG_FAIL, 0);
    check("reload_c16_p_en", 32'(p_en_po), 32'h1);
    check("reload_c16_val", 32'(p_value_po), 32'h0);
    for (int i = 17; i <= 24; i++) idle();
    check("reload_c24_p_en", 32'(p_en_po), 32'h1);
    idle();
    check("reload_c25_p_en", 32'(p_en_po), 32'h0);
    check("reload_c25_val", 32'(p_value_po), 32'h0);

    // Clear together with a request: clear wins, kind is retained.
    do_reset();
    for (int i = 1; i <= 5; i++) idle();
    step(0, 0, 16'h0, 1, MSG_PASS, 0);
    idle();
    step(0, 0, 16'h0, 1, MSG_FAIL, 1);
    check("clr_c8_p_en", 32'(p_en_po), 32'h0);
    check("clr_c8_busy", 32'(busy_po), 32'h0);
    check("clr_c8_val", 32'(p_value_po), 32'h1);
    idle();
    check("clr_c9_p_en", 32'(p_en_po), 32'h0);

    // Randomized traffic with occasional mid-run resets.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 3) == 0,
           16'($urandom),
           $urandom_range(0, 14) == 0,
           1'($urandom),
           $urandom_range(0, 39) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
